// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and widths for the MIPS pipeline stage registers
package pipe_pkg;
    localparam int IDEX_CTRL_W = 12;
    localparam int IDEX_DATA_W = 149;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_state_t;
    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] branch;
    } idex_ctrl_t;
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] imm_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] data_rs;
        logic [31:0] data_rt;
        logic [5:0]  func;
    } idex_data_t;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one ctrl+data register with load and clear; clear wins over load
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        q <= (reset | clear) ? '0 : load ? d : q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with optional skid slot, flush, bubbles and bubble counter
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              insert_bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);
    localparam int W = CTRL_W + DATA_W;
    occ_state_t state, state_n;
    logic [W-1:0] main_q, main_d, skid_q;
    logic accept, transfer, room;
    logic main_load, main_clear, skid_load, skid_clear;
    // In skid mode room depends only on registered state, so out_ready never reaches in_ready
    assign room      = (SKID != 0) ? (state != TWO) : (state == EMPTY || out_ready);
    assign in_ready  = room & ~insert_bubble & ~flush & ~reset;
    assign out_valid = state != EMPTY;
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;
    assign {out_ctrl, out_data} = main_q;
    assign occupancy = state;
    always_ff @(posedge clk)
        state <= reset ? EMPTY : state_n;
    always_comb begin
        state_n    = state;
        main_load  = (state == EMPTY && accept) || (state == ONE && accept && transfer) || (state == TWO && transfer);
        main_d     = (state == TWO) ? skid_q : {in_ctrl, in_data};
        main_clear = flush || (state == ONE && transfer && !accept);
        skid_load  = state == ONE && accept && !transfer;
        skid_clear = flush || (state == TWO && transfer);
        case (state)
            EMPTY:   state_n = accept ? ONE : EMPTY;
            ONE:     state_n = (accept && !transfer) ? TWO : (transfer && !accept) ? EMPTY : ONE;
            TWO:     state_n = transfer ? ONE : TWO;
            default: state_n = EMPTY;
        endcase
        if (flush)
            state_n = EMPTY;
    end
    pipe_slot #(.W(W)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q)
    );
    if (SKID != 0) begin : g_skid
        pipe_slot #(.W(W)) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (skid_load),
            .clear (skid_clear),
            .d     ({in_ctrl, in_data}),
            .q     (skid_q)
        );
    end else begin : g_noskid
        assign skid_q = '0;
    end
    // Counts offered inputs refused for a hazard, flush or not
    always_ff @(posedge clk)
        bubble_cnt <= reset ? '0 : (insert_bubble && in_valid && !(&bubble_cnt)) ? bubble_cnt + 1'b1 : bubble_cnt;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of skid (wide and 2-bit counter) and non-skid stage variants
module tb_pipe_stage_skid;
    import pipe_pkg::*;
    localparam int CW = IDEX_CTRL_W;
    localparam int DW = IDEX_DATA_W;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic insert_bubble = 1'b0;
    logic flush = 1'b0;
    logic out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic rdy1, ov1, rdy2, ov2, rdy0, ov0;
    logic [CW-1:0] ctrl1, ctrl2, ctrl0;
    logic [DW-1:0] data1, data2, data0;
    logic [1:0] occ1, occ2, occ0;
    logic [15:0] cnt1, cnt0;
    logic [1:0] cnt2;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    pipe_stage_skid #(.SKID(1), .CNT_W(16)) d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
        .insert_bubble(insert_bubble), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(ctrl1), .out_data(data1), .occupancy(occ1), .bubble_cnt(cnt1)
    );
    pipe_stage_skid #(.SKID(1), .CNT_W(2)) d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_ctrl(in_ctrl), .in_data(in_data),
        .insert_bubble(insert_bubble), .flush(flush), .out_valid(ov2), .out_ready(out_ready),
        .out_ctrl(ctrl2), .out_data(data2), .occupancy(occ2), .bubble_cnt(cnt2)
    );
    pipe_stage_skid #(.SKID(0), .CNT_W(16)) d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
        .insert_bubble(insert_bubble), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
        .out_ctrl(ctrl0), .out_data(data0), .occupancy(occ0), .bubble_cnt(cnt0)
    );
    function automatic logic [DW-1:0] dv(input int k);
        return {16'(k), 117'd0, ~16'(k)};
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic offer(input int k);
        in_valid = 1'b1;
        in_ctrl  = CW'(k);
        in_data  = dv(k);
    endtask
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        tick;
        offer(12'h0EE);
        #1;
        chk("rst_in_ready", rdy1, 0);
        chk("rst_in_ready_noskid", rdy0, 0);
        tick;
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_occ", occ1, 0);
        chk("rst_out_valid", ov1, 0);
        chk("rst_out_ctrl", ctrl1, 0);
        chk("rst_out_data", data1, 0);
        chk("rst_cnt", cnt1, 0);
        chk("idle_in_ready", rdy1, 1);
        // streaming at full rate
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            offer(k);
            #1;
            chk("stream_rdy", rdy1, 1);
            if (k > 1) begin
                chk("stream_ctrl", ctrl1, k - 1);
                chk("stream_occ", occ1, 1);
            end
            tick;
        end
        in_valid = 1'b0;
        #1;
        chk("stream_last_ctrl", ctrl1, 10);
        chk("stream_last_data", data1, dv(10));
        tick;
        #1;
        chk("stream_drain_occ", occ1, 0);
        chk("stream_drain_ctrl", ctrl1, 0);
        // backpressure fills the skid slot
        out_ready = 1'b0;
        offer(12'h0AA);
        #1;
        chk("bp_rdy_a", rdy1, 1);
        tick;
        offer(12'h0BB);
        #1;
        chk("bp_occ_one", occ1, 1);
        chk("bp_rdy_b", rdy1, 1);
        tick;
        offer(12'h0CC);
        #1;
        chk("bp_occ_two", occ1, 2);
        chk("bp_rdy_full", rdy1, 0);
        chk("bp_head_a", ctrl1, 12'h0AA);
        tick;
        out_ready = 1'b1;
        #1;
        chk("bp_hold_occ", occ1, 2);
        chk("bp_no_comb_ready", rdy1, 0);
        chk("bp_head_a2", data1, dv(12'h0AA));
        tick;
        #1;
        chk("bp_head_b", ctrl1, 12'h0BB);
        chk("bp_head_b_data", data1, dv(12'h0BB));
        chk("bp_occ_after", occ1, 1);
        chk("bp_skid_zero", d1.g_skid.u_skid.q, 0);
        chk("bp_rdy_c", rdy1, 1);
        tick;
        in_valid = 1'b0;
        #1;
        chk("bp_head_c", ctrl1, 12'h0CC);
        tick;
        #1;
        chk("bp_empty", occ1, 0);
        // flush with two entries and a concurrent transfer
        out_ready = 1'b0;
        offer(12'h0E1);
        tick;
        offer(12'h0F2);
        tick;
        offer(12'h033);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("fl_occ_two", occ1, 2);
        chk("fl_rdy", rdy1, 0);
        chk("fl_head", ctrl1, 12'h0E1);
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("fl_occ", occ1, 0);
        chk("fl_valid", ov1, 0);
        chk("fl_ctrl", ctrl1, 0);
        chk("fl_data", data1, 0);
        chk("fl_skid_zero", d1.g_skid.u_skid.q, 0);
        // load-use bubbles
        out_ready = 1'b1;
        offer(12'h044);
        insert_bubble = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bub_rdy", rdy1, 0);
            tick;
        end
        chk("bub_cnt3", cnt1, 3);
        chk("bub_cnt3_narrow", cnt2, 3);
        chk("bub_no_accept", occ1, 0);
        tick;
        tick;
        chk("bub_cnt5", cnt1, 5);
        chk("bub_sat", cnt2, 3);
        flush = 1'b1;
        tick;
        chk("bub_flush_cnt", cnt1, 6);
        flush = 1'b0;
        in_valid = 1'b0;
        tick;
        chk("bub_no_offer", cnt1, 6);
        chk("bub_no_offer_occ", occ1, 0);
        insert_bubble = 1'b0;
        // reset mid-stream at occupancy two
        out_ready = 1'b0;
        offer(12'h055);
        tick;
        offer(12'h066);
        tick;
        chk("mr_occ_two", occ1, 2);
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mr_rdy", rdy1, 0);
        tick;
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mr_occ", occ1, 0);
        chk("mr_valid", ov1, 0);
        chk("mr_ctrl", ctrl1, 0);
        chk("mr_data", data1, 0);
        chk("mr_cnt", cnt1, 0);
        chk("mr_cnt_narrow", cnt2, 0);
        chk("mr_skid", d1.g_skid.u_skid.q, 0);
        // single-slot mode: in_ready follows out_ready combinationally
        offer(12'h101);
        #1;
        chk("ns_rdy_empty", rdy0, 1);
        tick;
        offer(12'h102);
        #1;
        chk("ns_head1", ctrl0, 12'h101);
        chk("ns_rdy_pass", rdy0, 1);
        tick;
        offer(12'h103);
        out_ready = 1'b0;
        #1;
        chk("ns_head2", ctrl0, 12'h102);
        chk("ns_rdy_stall", rdy0, 0);
        tick;
        #1;
        chk("ns_hold", ctrl0, 12'h102);
        chk("ns_occ", occ0, 1);
        out_ready = 1'b1;
        #1;
        chk("ns_rdy_resume", rdy0, 1);
        tick;
        in_valid = 1'b0;
        #1;
        chk("ns_head3", ctrl0, 12'h103);
        chk("ns_head3_data", data0, dv(12'h103));
        tick;
        #1;
        chk("ns_drain", occ0, 0);
        chk("ns_drain_ctrl", ctrl0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
